// File: rtl/hello_pkg.sv
// hello_pkg: shared definitions for the HELLO scroller.
//   - 3-bit character codes understood by the downstream per-digit decoders
//   - scroll FSM state type
//   - msg_init(): builds the reset message "HELLO" + blanks, left-justified
//     so that the H sits on the leftmost digit (NUM_DIGITS-1).
package hello_pkg;

  localparam logic [2:0] CH_H     = 3'b000;
  localparam logic [2:0] CH_E     = 3'b001;
  localparam logic [2:0] CH_L     = 3'b010;
  localparam logic [2:0] CH_O     = 3'b011;
  localparam logic [2:0] CH_BLANK = 3'b111;

  // Upper bound on display width accepted by msg_init; the caller slices
  // the low 3*NUM_DIGITS bits out of the returned vector.
  localparam int MAX_DIGITS = 32;
  localparam int MSG_LEN    = 5;

  typedef enum logic {
    PAUSED  = 1'b0,
    RUNNING = 1'b1
  } state_t;

  // Returns the reset pattern: digit num_digits-1 down to num_digits-5 hold
  // H,E,L,L,O; every other slot is blank.
  function automatic logic [3*MAX_DIGITS-1:0] msg_init(input int num_digits);
    logic [3*MAX_DIGITS-1:0] m;
    logic [2:0]              ch;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      m[3*i +: 3] = CH_BLANK;
    end
    for (int k = 0; k < MSG_LEN; k++) begin
      case (k)
        0:       ch = CH_H;
        1:       ch = CH_E;
        2, 3:    ch = CH_L;
        default: ch = CH_O;
      endcase
      m[3*(num_digits-1-k) +: 3] = ch;
    end
    return m;
  endfunction

endpackage

// File: rtl/hello_scroller_if.sv
// hello_scroller_if: control inputs and display outputs of the scroller.
//   run, dir, step : asynchronous control levels from switches/buttons
//   char_codes     : 3 bits per digit, digit i at [3*i +: 3]
//   rot_pos        : net rotation offset modulo NUM_DIGITS
//   tick           : one-cycle pulse in the cycle a shift becomes visible
// master = driver of the controls (board/bench), slave = the scroller.
interface hello_scroller_if #(
  parameter int NUM_DIGITS = 8
);
  localparam int ROT_W = $clog2(NUM_DIGITS);

  logic                    run;
  logic                    dir;
  logic                    step;
  logic [3*NUM_DIGITS-1:0] char_codes;
  logic [ROT_W-1:0]        rot_pos;
  logic                    tick;

  modport master (
    output run, dir, step,
    input  char_codes, rot_pos, tick
  );

  modport slave (
    input  run, dir, step,
    output char_codes, rot_pos, tick
  );

endinterface

// File: rtl/tick_gen.sv
// tick_gen: prescaler for the auto-scroll rate.
//   clk   : clock
//   clr   : synchronous clear of the count (has priority over en)
//   en    : advance the count this cycle
//   pulse : high in the cycle where an enabled count sits at DIV-1; the
//           count wraps to 0 on that same edge
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic pulse
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= (count_reg == LAST) ? '0 : count_reg + 1'b1;
    end
  end

  assign pulse = en && (count_reg == LAST);

endmodule

// File: rtl/hello_scroller.sv
// hello_scroller: rotates "HELLO" + blanks across NUM_DIGITS display slots.
//   CLOCK_50 : system clock, rising edge
//   RESET    : synchronous active-high reset, highest priority
//   bus      : hello_scroller_if.slave (run/dir/step in; char_codes,
//              rot_pos, tick out -- all outputs registered)
// run/dir/step are resynchronised with two flops each. A rising step edge
// is registered before use, so a step reaches the display four clocks after
// the pin moves. While paused, a step edge shifts once; while running, the
// tick_gen prescaler shifts once every DIV = CLK_HZ/TICK_HZ clocks.
// DIV must be >= 2 and NUM_DIGITS >= 5.
module hello_scroller
  import hello_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int NUM_DIGITS = 8
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  hello_scroller_if.slave   bus
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int ROT_W = $clog2(NUM_DIGITS);
  localparam int CW    = 3 * NUM_DIGITS;

  localparam logic [3*MAX_DIGITS-1:0] INIT_FULL  = msg_init(NUM_DIGITS);
  localparam logic [CW-1:0]           INIT_CODES = INIT_FULL[CW-1:0];
  localparam logic [ROT_W-1:0]        ROT_LAST   = ROT_W'(NUM_DIGITS - 1);

  // ---------------------------------------------------------------------
  // Input synchronisers: bit 0 = run, bit 1 = dir, bit 2 = step
  // ---------------------------------------------------------------------
  logic [2:0] async_in;
  logic [2:0] sync_out;

  assign async_in = {bus.step, bus.dir, bus.run};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= async_in[gi];
          sync_reg <= meta_reg;
        end
      end

      assign sync_out[gi] = sync_reg;
    end
  endgenerate

  logic run_sync;
  logic dir_sync;
  logic step_sync;

  assign run_sync  = sync_out[0];
  assign dir_sync  = sync_out[1];
  assign step_sync = sync_out[2];

  // ---------------------------------------------------------------------
  // Step edge detect (registered, one pulse per rising edge of step)
  // ---------------------------------------------------------------------
  logic step_dly_reg;
  logic step_edge_reg;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;
  logic   step_shift;
  logic   running_stay;

  always_comb begin
    state_next = state_reg;
    step_shift = 1'b0;
    case (state_reg)
      PAUSED: begin
        // run wins over a coincident step edge: we start running and the
        // step is dropped.
        if (run_sync) begin
          state_next = RUNNING;
        end else if (step_edge_reg) begin
          step_shift = 1'b1;
        end
      end
      RUNNING: begin
        if (!run_sync) begin
          state_next = PAUSED;
        end
      end
      default: begin
        state_next = PAUSED;
      end
    endcase
  end

  // Prescaler only advances while we are in RUNNING and staying there; on
  // the exit cycle and throughout PAUSED it is held clear, so every entry
  // into RUNNING waits a full DIV period before the first shift.
  assign running_stay = (state_reg == RUNNING) && run_sync;

  logic presc_pulse;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (CLOCK_50),
    .clr   (RESET | ~running_stay),
    .en    (running_stay),
    .pulse (presc_pulse)
  );

  logic shift;
  assign shift = step_shift | presc_pulse;

  // ---------------------------------------------------------------------
  // Rotation datapath
  // ---------------------------------------------------------------------
  logic [CW-1:0]    codes_reg;
  logic [CW-1:0]    shifted;
  logic [ROT_W-1:0] rot_reg;
  logic [ROT_W-1:0] rot_next;
  logic             tick_reg;

  // Left (dir=0): each digit takes its right-hand neighbour, digit 0 takes
  // the leftmost. Right (dir=1): the mirror image.
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      localparam int LEFT_SRC  = (gi == 0) ? NUM_DIGITS - 1 : gi - 1;
      localparam int RIGHT_SRC = (gi == NUM_DIGITS - 1) ? 0 : gi + 1;

      assign shifted[3*gi +: 3] = dir_sync ? codes_reg[3*RIGHT_SRC +: 3]
                                           : codes_reg[3*LEFT_SRC +: 3];
    end
  endgenerate

  // Explicit wrap so NUM_DIGITS need not be a power of two.
  assign rot_next = dir_sync
                  ? ((rot_reg == '0)       ? ROT_LAST : rot_reg - 1'b1)
                  : ((rot_reg == ROT_LAST) ? '0       : rot_reg + 1'b1);

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_reg     <= PAUSED;
      step_dly_reg  <= 1'b0;
      step_edge_reg <= 1'b0;
      codes_reg     <= INIT_CODES;
      rot_reg       <= '0;
      tick_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_dly_reg  <= step_sync;
      step_edge_reg <= step_sync & ~step_dly_reg;
      tick_reg      <= shift;
      if (shift) begin
        codes_reg <= shifted;
        rot_reg   <= rot_next;
      end
    end
  end

  assign bus.char_codes = codes_reg;
  assign bus.rot_pos    = rot_reg;
  assign bus.tick       = tick_reg;

endmodule

// File: tb/tb_hello_scroller.sv
// tb_hello_scroller: scoreboard bench for hello_scroller (DIV=10, 8 digits).
// A reference process, clocked on the rising edge, keeps a history of the
// pin values seen at each edge and decides from the documented latencies
// (run -> RUNNING after 3 edges, step -> shift after 4 edges, dir seen 2
// edges late, one auto shift every 10 edges spent in RUNNING) whether a
// shift commits at that edge. The display is modelled as a rotation count:
// after r net left shifts digit i holds the reset character of digit
// (i - r) mod 8. Expected shifts are queued; a monitor on the falling edge
// pops one whenever tick is seen and compares cycle, rot_pos and codes.
module tb_hello_scroller;

  localparam int N      = 8;
  localparam int DIV    = 10;
  localparam int HIST   = 4096;
  localparam logic [23:0] RESET_CODES = 24'o01223777;

  typedef struct {
    int          cyc;
    int          rot;
    logic [23:0] codes;
  } exp_t;

  logic clk;
  logic rst;

  hello_scroller_if #(.NUM_DIGITS(N)) bus ();

  hello_scroller #(
    .CLK_HZ     (10),
    .TICK_HZ    (1),
    .NUM_DIGITS (N)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 8;
  int   m_rot    = 0;
  exp_t sb[$];

  bit run_h  [HIST];
  bit dir_h  [HIST];
  bit step_h [HIST];

  function automatic logic [23:0] pattern(input int r);
    logic [23:0] base;
    logic [23:0] p;
    base = RESET_CODES;
    for (int i = 0; i < N; i++) begin
      p[3*i +: 3] = base[3*((i - r + N) % N) +: 3];
    end
    return p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: no tick within the allowed window (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  initial begin
    int  run_len;
    bit  r_prev, r_now, do_shift;
    run_len = 0;
    forever begin
      @(posedge clk);
      cyc++;
      run_h[cyc]  = bus.run;
      dir_h[cyc]  = bus.dir;
      step_h[cyc] = bus.step;
      if (rst) begin
        // synchronisers and edge detector are cleared: older pin history
        // must no longer influence anything
        for (int j = 0; j < 4; j++) begin
          run_h[cyc-j]  = 1'b0;
          dir_h[cyc-j]  = 1'b0;
          step_h[cyc-j] = 1'b0;
        end
        m_rot   = 0;
        run_len = 0;
        sb.delete();
      end else begin
        r_prev   = run_h[cyc-3];
        r_now    = run_h[cyc-2];
        do_shift = 1'b0;
        if (r_prev && r_now) begin
          run_len++;
          if (run_len % DIV == 0) do_shift = 1'b1;
        end else begin
          run_len = 0;
        end
        if (!r_prev && !r_now && step_h[cyc-3] && !step_h[cyc-4]) do_shift = 1'b1;
        if (do_shift) begin
          m_rot = dir_h[cyc-2] ? (m_rot + N - 1) % N : (m_rot + 1) % N;
          sb.push_back('{cyc, m_rot, pattern(m_rot)});
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tick) begin
        if (sb.size() == 0) begin
          check("unexpected_tick", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          $display("shift  cycle=%0d rot_pos=%0d codes=%o", cyc, bus.rot_pos, bus.char_codes);
          check("tick_cycle", 64'(cyc), 64'(e.cyc));
          check("tick_rot_pos", 64'(bus.rot_pos), 64'(e.rot));
          check("tick_codes", 64'(bus.char_codes), 64'(e.codes));
        end
      end else begin
        if (sb.size() > 0 && sb[0].cyc <= cyc) begin
          e = sb.pop_front();
          check("missing_tick", 64'd0, 64'd1);
        end
        check("idle_rot_pos", 64'(bus.rot_pos), 64'(m_rot));
        check("idle_codes", 64'(bus.char_codes), 64'(pattern(m_rot)));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick(input int max_cycles, output int at, output bit found);
    found = 1'b0;
    at    = -1;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (bus.tick) begin
        at    = cyc;
        found = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int          c, t, t2;
    bit          found;
    logic [23:0] codes;

    rst = 1'b1; bus.run = 1'b0; bus.dir = 1'b0; bus.step = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(1);

    // 1. reset state
    check("reset_codes", 64'(bus.char_codes), 64'(RESET_CODES));
    check("reset_rot_pos", 64'(bus.rot_pos), 64'd0);
    check("reset_tick", 64'(bus.tick), 64'd0);

    // 2. continuous left run: first tick 13 clocks after run rises
    c = cyc;
    bus.run = 1'b1;
    wait_tick(30, t, found);
    if (!found) fail_now("first_tick");
    else begin
      check("first_tick_latency", 64'(t - c), 64'd13);
      codes = bus.char_codes;
      check("first_shift_digit7", 64'(codes[23:21]), 64'(hello_pkg::CH_E));
      check("first_shift_digit0", 64'(codes[2:0]), 64'(hello_pkg::CH_H));
      check("first_shift_rot_pos", 64'(bus.rot_pos), 64'd1);
    end
    wait_tick(15, t2, found);
    if (!found) fail_now("second_tick");
    else check("tick_period", 64'(t2 - t), 64'd10);

    // 3. complete a full left revolution, then one right shift
    for (int i = 0; i < 6; i++) begin
      wait_tick(15, t, found);
      if (!found) fail_now("revolution_tick");
    end
    check("wrap_rot_pos", 64'(bus.rot_pos), 64'd0);
    check("wrap_codes", 64'(bus.char_codes), 64'(RESET_CODES));
    bus.dir = 1'b1;
    wait_tick(15, t, found);
    if (!found) fail_now("right_tick");
    else begin
      codes = bus.char_codes;
      check("right_rot_pos", 64'(bus.rot_pos), 64'd7);
      check("right_digit7", 64'(codes[23:21]), 64'(hello_pkg::CH_BLANK));
      check("right_digit6", 64'(codes[20:18]), 64'(hello_pkg::CH_H));
    end
    bus.run = 1'b0; bus.dir = 1'b0;
    cycles(12);

    // 4. manual steps: 1-clock and 20-clock pulses, then steps while running
    c = cyc;
    bus.step = 1'b1;
    cycles(1);
    bus.step = 1'b0;
    wait_tick(10, t, found);
    if (!found) fail_now("step_short");
    else check("step_short_latency", 64'(t - c), 64'd4);
    cycles(10);
    c = cyc;
    bus.step = 1'b1;
    wait_tick(10, t, found);
    if (!found) fail_now("step_long");
    else check("step_long_latency", 64'(t - c), 64'd4);
    cycles(16);
    bus.step = 1'b0;
    cycles(10);
    bus.run = 1'b1;
    cycles(3);
    for (int i = 0; i < 5; i++) begin
      bus.step = 1'b1; cycles(2);
      bus.step = 1'b0; cycles(3);
    end
    bus.run = 1'b0;
    cycles(12);

    // 5. run and step rise together: only the prescaler shifts
    c = cyc;
    bus.run = 1'b1; bus.step = 1'b1;
    wait_tick(20, t, found);
    if (!found) fail_now("conflict_tick");
    else check("conflict_first_tick", 64'(t - c), 64'd13);
    bus.step = 1'b0; bus.run = 1'b0;
    cycles(10);

    // 6. reset landing on the prescaler's last count
    bus.run = 1'b1;
    wait_tick(20, t, found);
    if (!found) fail_now("pre_reset_tick");
    cycles(9);
    rst = 1'b1; bus.run = 1'b0;
    cycles(1);
    rst = 1'b0;
    check("reset_abort_tick", 64'(bus.tick), 64'd0);
    check("reset_abort_codes", 64'(bus.char_codes), 64'(RESET_CODES));
    check("reset_abort_rot_pos", 64'(bus.rot_pos), 64'd0);
    wait_tick(30, t, found);
    check("stays_paused", 64'(found), 64'd0);

    // random traffic, including occasional resets
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(39, 0) == 0) bus.run = ~bus.run;
      if ($urandom_range(29, 0) == 0) bus.dir = ~bus.dir;
      if ($urandom_range(5, 0) == 0)  bus.step = ~bus.step;
      rst = ($urandom_range(299, 0) == 0);
      cycles(1);
    end
    rst = 1'b0; bus.run = 1'b0; bus.step = 1'b0;
    cycles(20);
    check("scoreboard_drain", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
